// File: rtl/pacman_sprite_drawer.sv
// Pac-Man sprite pixel renderer.
// Takes the VGA scan position and produces a registered per-pixel "sprite is
// opaque here" flag, two Clk cycles after DrawX/DrawY are presented. The
// sprite comes from an external combinational 32x32 ROM: one 32-bit row per
// 5-bit address, with bit 31 as the leftmost pixel.
// Sprite position and facing are latched once per frame so that a change in
// the middle of a frame cannot tear the image. The mouth animates while the
// sprite is moving.
//
// Ports
//   Clk        in   pixel clock; all state updates on the rising edge
//   Reset_n    in   asynchronous active-low reset
//   frame_clk  in   per-frame signal (vsync); its rising edge is detected here
//   DrawX/Y    in   current scan coordinates
//   PosX/Y     in   requested sprite top-left corner, sampled on a frame edge
//   dir        in   facing direction (0 right, 1 left, 2 up, 3 down), sampled on a frame edge
//   moving     in   animation enable, sampled on a frame edge
//   rom_addr   out  sprite ROM row address, driven from the stage-1 registers
//   rom_data   in   sprite ROM row, valid in the same cycle as rom_addr
//   is_pac     out  opaque flag for the pixel presented two clocks earlier
module pacman_sprite_drawer #(
  parameter logic [9:0]  START_X     = 10'd304,
  parameter logic [9:0]  START_Y     = 10'd224,
  parameter int unsigned ANIM_FRAMES = 8
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  PosX,
  input  logic [9:0]  PosY,
  input  logic [1:0]  dir,
  input  logic        moving,
  output logic [4:0]  rom_addr,
  input  logic [31:0] rom_data,
  output logic        is_pac
);

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_t;

  localparam int unsigned        CW        = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam logic [CW-1:0]      ANIM_LAST = CW'(ANIM_FRAMES - 1);

  logic          frame_clk_q;
  logic          fe;
  logic [9:0]    pos_x_q;
  logic [9:0]    pos_y_q;
  dir_t          dir_q;
  logic [CW-1:0] anim_cnt;
  logic          mouth_open;

  logic [4:0]    row_sel;
  logic [4:0]    col_sel;
  logic          in_box_1;
  logic          mouth_open_1;

  logic [4:0]    rx;
  logic [4:0]    ry;
  logic          in_box_d;
  logic [4:0]    row_d;
  logic [4:0]    col_d;
  logic [31:0]   rev;
  logic [31:0]   line;

  assign fe = frame_clk & ~frame_clk_q;

  // Per-frame geometry latch and mouth animation.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_clk_q <= 1'b0;
      pos_x_q     <= START_X;
      pos_y_q     <= START_Y;
      dir_q       <= DIR_RIGHT;
      anim_cnt    <= '0;
      mouth_open  <= 1'b1;
    end else begin
      frame_clk_q <= frame_clk;
      if (fe) begin
        pos_x_q <= PosX;
        pos_y_q <= PosY;
        dir_q   <= dir_t'(dir);
        if (!moving) begin
          anim_cnt   <= '0;
          mouth_open <= 1'b1;
        end else if (anim_cnt == ANIM_LAST) begin
          anim_cnt   <= '0;
          mouth_open <= ~mouth_open;
        end else begin
          anim_cnt <= anim_cnt + CW'(1);
        end
      end
    end
  end

  // Sprite-relative coordinates only need the low 5 bits; the box test is
  // done in 11 bits so a sprite near x/y=1023 does not alias onto low columns.
  always_comb begin
    rx       = DrawX[4:0] - pos_x_q[4:0];
    ry       = DrawY[4:0] - pos_y_q[4:0];
    in_box_d = ({1'b0, DrawX} >= {1'b0, pos_x_q}) &&
               ({1'b0, DrawX} <  ({1'b0, pos_x_q} + 11'd32)) &&
               ({1'b0, DrawY} >= {1'b0, pos_y_q}) &&
               ({1'b0, DrawY} <  ({1'b0, pos_y_q} + 11'd32));
    row_d = ry;
    col_d = rx;
    case (dir_q)
      DIR_RIGHT: begin row_d = ry; col_d = rx;  end
      DIR_LEFT:  begin row_d = ry; col_d = ~rx; end
      DIR_UP:    begin row_d = rx; col_d = ~ry; end
      DIR_DOWN:  begin row_d = rx; col_d = ry;  end
      default:   begin row_d = ry; col_d = rx;  end
    endcase
  end

  // Stage 1: sprite row/column selection.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      row_sel      <= '0;
      col_sel      <= '0;
      in_box_1     <= 1'b0;
      mouth_open_1 <= 1'b0;
    end else begin
      row_sel      <= row_d;
      col_sel      <= col_d;
      in_box_1     <= in_box_d;
      mouth_open_1 <= mouth_open;
    end
  end

  assign rom_addr = row_sel;

  // A closed mouth is drawn by mirroring the solid back half over the opening.
  always_comb begin
    rev = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      rev[i] = rom_data[31 - i];
    end
    line = mouth_open_1 ? rom_data : (rom_data | rev);
  end

  // Stage 2: pixel lookup; column 0 is bit 31.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      is_pac <= 1'b0;
    end else begin
      is_pac <= in_box_1 & line[~col_sel];
    end
  end

endmodule

// File: tb/tb_pacman_sprite_drawer.sv
module tb_pacman_sprite_drawer;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_clk = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic [9:0]  PosX = 10'd304;
  logic [9:0]  PosY = 10'd224;
  logic [1:0]  dir = 2'd0;
  logic        moving = 1'b0;
  logic [4:0]  rom_addr;
  logic [31:0] rom_data;
  logic        is_pac;

  int total = 0;
  int bad   = 0;

  pacman_sprite_drawer #(
    .START_X(10'd304),
    .START_Y(10'd224),
    .ANIM_FRAMES(8)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .frame_clk(frame_clk),
    .DrawX(DrawX),
    .DrawY(DrawY),
    .PosX(PosX),
    .PosY(PosY),
    .dir(dir),
    .moving(moving),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .is_pac(is_pac)
  );

  always #5 Clk = ~Clk;

  // Sprite ROM: a disc of diameter 32 with a 90-degree mouth opening right.
  // With a = 2r-31, b = 2c-31: opaque when a*a+b*b <= 961 and not |a| <= b.
  function automatic logic [31:0] rom_row(input logic [4:0] r);
    logic [31:0] v;
    int a;
    int b;
    v = '0;
    a = 2 * int'(r) - 31;
    for (int c = 0; c < 32; c++) begin
      b = 2 * c - 31;
      if ((a * a + b * b <= 961) && !(a <= b && -a <= b))
        v[31 - c] = 1'b1;
    end
    return v;
  endfunction

  always_comb rom_data = rom_row(rom_addr);

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic frame();
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) frame_clk = 1'b0;
  endtask

  task automatic pix(input string name, input logic [9:0] x, input logic [9:0] y,
                     input logic exp_pac, input logic [4:0] exp_addr);
    @(negedge Clk);
    DrawX = x;
    DrawY = y;
    @(posedge Clk) #1;
    check({name, ".addr"}, int'(rom_addr), int'(exp_addr));
    @(posedge Clk) #1;
    check({name, ".pac"}, int'(is_pac), int'(exp_pac));
  endtask

  task automatic pac_only(input string name, input logic [9:0] x, input logic [9:0] y,
                          input logic exp_pac);
    @(negedge Clk);
    DrawX = x;
    DrawY = y;
    @(posedge Clk);
    @(posedge Clk) #1;
    check(name, int'(is_pac), int'(exp_pac));
  endtask

  typedef struct {
    logic [1:0] d;
    logic [9:0] px;
    logic [9:0] py;
    logic [9:0] x;
    logic [9:0] y;
    logic       pac;
    logic [4:0] addr;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{2'd0, 10'd304,  10'd224, 10'd320,  10'd234, 1'b1, 5'd10}; // row10 col16
    vecs[1]  = '{2'd0, 10'd304,  10'd224, 10'd303,  10'd234, 1'b0, 5'd10}; // left of box
    vecs[2]  = '{2'd0, 10'd304,  10'd224, 10'd328,  10'd238, 1'b0, 5'd14}; // mouth row14 col24
    vecs[3]  = '{2'd0, 10'd304,  10'd224, 10'd311,  10'd238, 1'b1, 5'd14}; // back row14 col7
    vecs[4]  = '{2'd0, 10'd304,  10'd224, 10'd304,  10'd224, 1'b0, 5'd0};  // corner outside disc
    vecs[5]  = '{2'd1, 10'd304,  10'd224, 10'd306,  10'd238, 1'b0, 5'd14}; // left: row14 col29
    vecs[6]  = '{2'd1, 10'd304,  10'd224, 10'd329,  10'd238, 1'b1, 5'd14}; // left: row14 col6
    vecs[7]  = '{2'd2, 10'd304,  10'd224, 10'd318,  10'd226, 1'b0, 5'd14}; // up: row14 col29
    vecs[8]  = '{2'd2, 10'd304,  10'd224, 10'd318,  10'd250, 1'b1, 5'd14}; // up: row14 col5
    vecs[9]  = '{2'd3, 10'd304,  10'd224, 10'd318,  10'd254, 1'b0, 5'd14}; // down: row14 col30
    vecs[10] = '{2'd3, 10'd304,  10'd224, 10'd318,  10'd232, 1'b1, 5'd14}; // down: row14 col8
    vecs[11] = '{2'd0, 10'd1000, 10'd224, 10'd0,    10'd230, 1'b0, 5'd6};  // would alias to opaque row6 col24
    vecs[12] = '{2'd0, 10'd1000, 10'd224, 10'd1010, 10'd234, 1'b1, 5'd10}; // row10 col10
    vecs[13] = '{2'd0, 10'd1000, 10'd224, 10'd1023, 10'd230, 1'b1, 5'd6};  // row6 col23 at x=1023

    // Reset state, then default position with no frame edge.
    DrawX = 10'd320;
    DrawY = 10'd234;
    #1;
    check("reset.pac", int'(is_pac), 0);
    check("reset.addr", int'(rom_addr), 0);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    pix("default", 10'd320, 10'd234, 1'b1, 5'd10);

    for (int i = 0; i < 14; i++) begin
      dir    = vecs[i].d;
      PosX   = vecs[i].px;
      PosY   = vecs[i].py;
      moving = 1'b0;
      frame();
      pix($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].pac, vecs[i].addr);
    end

    // Mouth animation: toggles on the 8th moving frame edge.
    dir    = 2'd0;
    PosX   = 10'd304;
    PosY   = 10'd224;
    moving = 1'b1;
    repeat (7) frame();
    pac_only("anim7", 10'd328, 10'd238, 1'b0);
    frame();
    pac_only("anim8_closed", 10'd328, 10'd238, 1'b1);
    repeat (3) frame();
    pac_only("anim11_closed", 10'd328, 10'd238, 1'b1);
    moving = 1'b0;
    frame();
    pac_only("park_open", 10'd328, 10'd238, 1'b0);
    moving = 1'b1;
    repeat (7) frame();
    pac_only("cnt_restart7", 10'd328, 10'd238, 1'b0);
    frame();
    pac_only("cnt_restart8", 10'd328, 10'd238, 1'b1);
    repeat (8) frame();
    pac_only("reopen", 10'd328, 10'd238, 1'b0);

    // Position change without a frame edge has no effect.
    moving = 1'b0;
    frame();
    pix("pre_move", 10'd320, 10'd234, 1'b1, 5'd10);
    PosX = 10'd320;
    pix("midframe", 10'd320, 10'd234, 1'b1, 5'd10);
    frame();
    pix("moved_old", 10'd320, 10'd234, 1'b0, 5'd10);
    pix("moved_new", 10'd336, 10'd234, 1'b1, 5'd10);

    // Frame edge coincident with a pixel: that pixel keeps old geometry.
    PosX = 10'd304;
    frame();
    @(negedge Clk);
    DrawX     = 10'd320;
    DrawY     = 10'd234;
    PosX      = 10'd320;
    frame_clk = 1'b1;
    @(negedge Clk);
    frame_clk = 1'b0;
    @(posedge Clk) #1;
    check("fe_inflight_old", int'(is_pac), 1);
    @(posedge Clk) #1;
    check("fe_inflight_new", int'(is_pac), 0);
    pix("fe_after", 10'd336, 10'd234, 1'b1, 5'd10);

    // Reset mid-scan: immediate clear, position back to START, 2-clock refill.
    @(negedge Clk);
    DrawX = 10'd336;
    @(posedge Clk);
    @(posedge Clk) #1;
    check("pre_reset", int'(is_pac), 1);
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    check("rst_pac", int'(is_pac), 0);
    check("rst_addr", int'(rom_addr), 0);
    repeat (2) @(negedge Clk);
    DrawX   = 10'd320;
    Reset_n = 1'b1;
    @(posedge Clk) #1;
    check("rel_pac1", int'(is_pac), 0);
    check("rel_addr1", int'(rom_addr), 10);
    @(posedge Clk) #1;
    check("rel_pac2_start", int'(is_pac), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
